lsu_access_seq: RTL and testbench

LSU_ACCESS_SEQ -- requirements
Module: lsu_access_seq

---
 rtl/lsu_access_seq.sv | 180 ++++++++++++++++++
 tb/tb_lsu_access_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access_seq.sv
// lsu_access_seq: load/store access sequencer between the pipeline and a
// byte-addressed data memory. Aligned requests take one ACCESS cycle; illegal
// or out-of-range requests take one FAULT cycle with no memory traffic.
// Optional macro LSU_MISALIGN_EN: misaligned legal requests are broken into
// one byte access per cycle (SPLIT). Without it they are reported as faults.
module lsu_access_seq #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_we,
  output logic [2:0]  mem_re,
  input  logic [31:0] mem_data_out,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        resp_misaligned
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, FAULT
`ifdef LSU_MISALIGN_EN
    , SPLIT
`endif
  } state_t;

  state_t      state;
  logic        lat_store;
  logic        pend_mis;

  // request decode: access size is mask+1 (1, 2 or 4 bytes)
  logic [1:0]  req_mask;
  logic        req_mis, req_legal, req_oor, req_fault;
  logic [32:0] req_end;
  logic [1:0]  we_code;
  logic [2:0]  re_code;

  // classify the presented request against size, legality and memory range
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    req_mask = 2'b00;
      2'd1:    req_mask = 2'b01;
      default: req_mask = 2'b11;
    endcase
    req_mis   = |(req_addr[1:0] & req_mask);
    req_legal = req_store ? (req_funct3 <= 3'd2)
                          : (req_funct3 != 3'd3 && req_funct3 <= 3'd5);
    // 33-bit end address so addresses near 2^32 cannot wrap into range
    req_end   = {1'b0, req_addr} + {31'b0, req_mask};
    req_oor   = req_end >= 33'(MEM_BYTES);
`ifdef LSU_MISALIGN_EN
    req_fault = !req_legal || req_oor;
`else
    req_fault = !req_legal || req_oor || req_mis;
`endif
    we_code   = req_funct3[1:0] + 2'd1;
    re_code   = req_funct3[2] ? req_funct3 : req_funct3 + 3'd1;
  end

`ifdef LSU_MISALIGN_EN
  logic [1:0]  k, kn, lat_mask;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr, lat_wdata, res, merged, ext;

  // fold the byte returned this cycle into the partial result and extend it
  always_comb begin
    kn     = k + 2'd1;
    merged = res;
    merged[{k, 3'b000} +: 8] = mem_data_out[7:0];
    case (lat_f3)
      3'd1:    ext = {{16{merged[15]}}, merged[15:0]};
      3'd5:    ext = {16'h0, merged[15:0]};
      default: ext = merged;
    endcase
  end
`endif

  assign req_ready = (state == IDLE);

  // sequencer: all memory strobes and response fields are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      lat_store       <= 1'b0;
      pend_mis        <= 1'b0;
      mem_address     <= '0;
      mem_data_in     <= '0;
      mem_we          <= '0;
      mem_re          <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_fault      <= 1'b0;
      resp_misaligned <= 1'b0;
`ifdef LSU_MISALIGN_EN
      k         <= '0;
      lat_mask  <= '0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      res       <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          lat_store <= req_store;
          pend_mis  <= req_mis;
          if (req_fault) begin
            state <= FAULT;
          end else if (!req_mis) begin
            state       <= ACCESS;
            mem_address <= req_addr;
            mem_data_in <= req_wdata;
            mem_we      <= req_store ? we_code : 2'd0;
            mem_re      <= req_store ? 3'd0 : re_code;
          end
`ifdef LSU_MISALIGN_EN
          else begin
            state       <= SPLIT;
            k           <= '0;
            lat_mask    <= req_mask;
            lat_f3      <= req_funct3;
            lat_addr    <= req_addr;
            lat_wdata   <= req_wdata;
            res         <= '0;
            mem_address <= req_addr;
            mem_data_in <= {24'h0, req_wdata[7:0]};
            mem_we      <= req_store ? 2'd1 : 2'd0;
            mem_re      <= req_store ? 3'd0 : 3'd4;
          end
`endif
        end
        ACCESS: begin
          state           <= IDLE;
          mem_we          <= '0;
          mem_re          <= '0;
          resp_valid      <= 1'b1;
          resp_rdata      <= lat_store ? 32'h0 : mem_data_out;
          resp_fault      <= 1'b0;
          resp_misaligned <= 1'b0;
        end
        FAULT: begin
          state           <= IDLE;
          resp_valid      <= 1'b1;
          resp_rdata      <= '0;
          resp_fault      <= 1'b1;
          resp_misaligned <= pend_mis;
        end
`ifdef LSU_MISALIGN_EN
        SPLIT: begin
          if (k == lat_mask) begin
            state           <= IDLE;
            mem_we          <= '0;
            mem_re          <= '0;
            resp_valid      <= 1'b1;
            resp_rdata      <= lat_store ? 32'h0 : ext;
            resp_fault      <= 1'b0;
            resp_misaligned <= 1'b1;
          end else begin
            k           <= kn;
            res         <= merged;
            mem_address <= lat_addr + {30'b0, kn};
            mem_data_in <= {24'h0, lat_wdata[{kn, 3'b000} +: 8]};
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_access_seq.sv
// Bench for lsu_access_seq: byte memory behind the DUT, a request-level
// reference model that predicts every cycle of memory traffic and responses,
// directed literal cases and randomized requests.
module tb_lsu_access_seq;

`ifdef LSU_MISALIGN_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_we;
  logic [2:0]  mem_re;
  logic        resp_valid, resp_fault, resp_misaligned;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  lsu_access_seq #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_re(mem_re), .mem_data_out(mem_data_out),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_misaligned(resp_misaligned));

  int total = 0, bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // data memory seen by the DUT; rmem is the model's view of the same bytes
  logic [7:0] dmem [64];
  logic [7:0] rmem [64];
  logic       mem_init = 1'b1;
  logic [5:0] ma;

  always_comb begin
    ma = mem_address[5:0];
    case (mem_re)
      3'd1:    mem_data_out = {{24{dmem[ma][7]}}, dmem[ma]};
      3'd2:    mem_data_out = {{16{dmem[ma+6'd1][7]}}, dmem[ma+6'd1], dmem[ma]};
      3'd3:    mem_data_out = {dmem[ma+6'd3], dmem[ma+6'd2], dmem[ma+6'd1], dmem[ma]};
      3'd4:    mem_data_out = {24'h0, dmem[ma]};
      3'd5:    mem_data_out = {16'h0, dmem[ma+6'd1], dmem[ma]};
      default: mem_data_out = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= rmem[i];
    end else begin
      case (mem_we)
        2'd1: dmem[ma] <= mem_data_in[7:0];
        2'd2: begin dmem[ma] <= mem_data_in[7:0]; dmem[ma+6'd1] <= mem_data_in[15:8]; end
        2'd3: begin
          dmem[ma] <= mem_data_in[7:0];     dmem[ma+6'd1] <= mem_data_in[15:8];
          dmem[ma+6'd2] <= mem_data_in[23:16]; dmem[ma+6'd3] <= mem_data_in[31:24];
        end
        default: ;
      endcase
    end
  end

  // expected per-cycle view; an empty queue means "idle"
  typedef struct {
    logic ready; logic [1:0] we; logic [2:0] re; logic rv;
    logic achk; logic [31:0] addr; logic [31:0] dmask; logic [31:0] din;
    logic [31:0] rdata; logic fault; logic mis;
  } rec_t;
  rec_t expq[$];
  logic [31:0] h_rdata = '0;
  logic        h_fault = 1'b0, h_mis = 1'b0;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    rec_t r;
    if (reset) begin
      h_rdata = '0; h_fault = 1'b0; h_mis = 1'b0;
    end else if (chk_en) begin
      if (expq.size() > 0) r = expq.pop_front();
      else r = '{1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      if (r.rv) begin h_rdata = r.rdata; h_fault = r.fault; h_mis = r.mis; end
      chk("req_ready", {31'b0, req_ready}, {31'b0, r.ready});
      chk("mem_we", {30'b0, mem_we}, {30'b0, r.we});
      chk("mem_re", {29'b0, mem_re}, {29'b0, r.re});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, r.rv});
      if (r.achk) chk("mem_address", mem_address, r.addr);
      if (r.dmask != 0) chk("mem_data_in", mem_data_in & r.dmask, r.din & r.dmask);
      chk("resp_rdata", resp_rdata, h_rdata);
      chk("resp_fault", {31'b0, resp_fault}, {31'b0, h_fault});
      chk("resp_misaligned", {31'b0, resp_misaligned}, {31'b0, h_mis});
    end
  end

  // load result straight from the specification: little-endian bytes, extended
  function automatic logic [31:0] load_val(logic [31:0] ad, logic [2:0] f3);
    logic [31:0] v = 0;
    int sz = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    for (int i = 0; i < sz; i++) v = v | (32'(rmem[ad + i]) << (8 * i));
    case (f3)
      3'd0: v = {{24{v[7]}}, v[7:0]};
      3'd1: v = {{16{v[15]}}, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  // drive one request (DUT assumed idle), queue its expected cycles, and
  // return at the start of its response cycle
  task automatic do_req(bit st, logic [2:0] f3, logic [31:0] ad, logic [31:0] wd, bit hold);
    int sz, nb;
    bit mis, legal, fault;
    longint e;
    rec_t r;
    logic [31:0] val = 0;
    sz    = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    mis   = (ad % sz) != 0;
    legal = st ? (f3 <= 2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e     = longint'(ad) + sz - 1;
    fault = !legal || (e >= 64) || (mis && !MEN);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = ad; req_wdata = wd;
    @(posedge clk);
    r = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    if (fault) begin
      expq.push_back(r); nb = 1;
    end else begin
      if (!st) val = load_val(ad, f3);
      else for (int i = 0; i < sz; i++) rmem[ad + i] = wd[8*i +: 8];
      if (!mis) begin
        r.we = st ? 2'(f3[1:0] + 1) : 2'd0;
        r.re = st ? 3'd0 : (f3 < 4 ? f3 + 3'd1 : f3);
        r.achk = 1'b1; r.addr = ad; r.dmask = 32'hFFFF_FFFF; r.din = wd;
        expq.push_back(r); nb = 1;
      end else begin
        for (int k = 0; k < sz; k++) begin
          r.we = st ? 2'd1 : 2'd0; r.re = st ? 3'd0 : 3'd4;
          r.achk = 1'b1; r.addr = ad + k;
          r.dmask = st ? 32'hFF : 32'h0; r.din = (wd >> (8 * k)) & 32'hFF;
          expq.push_back(r);
        end
        nb = sz;
      end
    end
    r = '{1'b1, 2'd0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
          st ? 32'h0 : val, fault, (fault || !mis) ? (fault & mis) : 1'b1};
    expq.push_back(r);
    #1;
    if (hold) begin
      req_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom % 64; req_wdata = $urandom;
    end else req_valid = 1'b0;
    repeat (nb) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int nmis;
    for (int i = 0; i < 64; i++) rmem[i] = 8'($urandom);
    // a valid request held during reset must not be accepted
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'd0; req_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0; mem_init = 1'b0;
    chk("reset ready", {31'b0, req_ready}, 32'd1);
    chk("reset mem_we/re", {27'b0, mem_we, mem_re}, 32'd0);
    chk("reset mem_address", mem_address, 32'd0);
    chk("reset mem_data_in", mem_data_in, 32'd0);
    chk("reset resp", {resp_rdata[29:0], resp_valid, resp_fault | resp_misaligned}, 32'd0);
    chk_en = 1'b1;
    idle();

    // word store then load at 8
    do_req(1, 3'd2, 32'd8, 32'hDEAD_BEEF, 0);
    chk("sw8 resp_valid", {31'b0, resp_valid}, 32'd1);
    do_req(0, 3'd2, 32'd8, 32'h0, 0);
    chk("lw8 rdata", resp_rdata, 32'hDEAD_BEEF);

    // bytes 5..10 = 80 01 02 03 80 FF, chained back to back with held valid
    do_req(1, 3'd0, 32'd5, 32'h80, 1);
    do_req(1, 3'd0, 32'd6, 32'h01, 1);
    do_req(1, 3'd0, 32'd7, 32'h02, 1);
    do_req(1, 3'd0, 32'd8, 32'h03, 1);
    do_req(1, 3'd0, 32'd9, 32'h80, 1);
    do_req(1, 3'd0, 32'd10, 32'hFF, 0);
    do_req(0, 3'd2, 32'd5, 32'h0, 0);
    chk("lw5 rdata", resp_rdata, MEN ? 32'h0302_0180 : 32'h0);
    chk("lw5 flags", {30'b0, resp_fault, resp_misaligned}, MEN ? 32'd1 : 32'd3);
    do_req(0, 3'd1, 32'd9, 32'h0, 0);
    chk("lh9 rdata", resp_rdata, MEN ? 32'hFFFF_FF80 : 32'h0);
    do_req(0, 3'd5, 32'd9, 32'h0, 0);
    chk("lhu9 rdata", resp_rdata, MEN ? 32'h0000_FF80 : 32'h0);
    do_req(0, 3'd2, 32'd62, 32'h0, 0);
    chk("lw62 fault", {31'b0, resp_fault}, 32'd1);
    do_req(0, 3'd3, 32'd0, 32'h0, 0);
    chk("ld f3=3 fault", {resp_rdata[30:0], resp_fault}, 32'd1);
    idle();

    // reset in the middle of a misaligned store (or its fault cycle)
    chk_en = 1'b0;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd1; req_addr = 32'd3; req_wdata = 32'hAABB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort first cycle we", {30'b0, mem_we}, MEN ? 32'd1 : 32'd0);
    if (MEN) begin
      chk("abort first cycle addr", mem_address, 32'd3);
      chk("abort first cycle din", mem_data_in & 32'hFF, 32'hBB);
      rmem[3] = 8'hBB;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort outputs", {mem_address[22:0], mem_we, mem_re, resp_valid, resp_fault, resp_misaligned, req_ready}, 32'd1);
    chk("abort out data", mem_data_in | resp_rdata, 32'd0);
    chk_en = 1'b1;
    repeat (3) idle();
    chk("abort byte3", {24'b0, dmem[3]}, {24'b0, rmem[3]});
    chk("abort byte4", {24'b0, dmem[4]}, {24'b0, rmem[4]});

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit st = 1'($urandom);
      logic [2:0] f3 = 3'($urandom);
      logic [31:0] ad;
      if ($urandom % 4 != 0) f3 = st ? 3'($urandom % 3) : lf[$urandom % 5];
      case ($urandom % 8)
        0: ad = 32'd56 + ($urandom % 8);
        1: ad = $urandom | 32'h8000_0000;
        default: ad = $urandom % 64;
      endcase
      do_req(st, f3, ad, $urandom, 1'($urandom));
      if ($urandom % 3 == 0) idle();
    end
    repeat (3) idle();

    nmis = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== rmem[i]) nmis++;
    chk("memory image mismatches", 32'(nmis), 32'd0);
    chk("expect queue drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
